// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-to-1 channel selector feeding one registered valid/ready output slot.
// Define RR_ARB_EN to replace the external select with an internal round-robin arbiter.
module mux_nto1_pipe #(
  parameter  int W  = 5,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [N-1:0]  grant;
  logic          canLoad;
  logic          xfer;
  logic [W-1:0]  loadData;
  logic [SW-1:0] loadChan;

  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] chan_q, chan_d;
  logic          valid_q, valid_d;

  assign canLoad  = !valid_q || out_ready;
  assign in_ready = grant & {N{canLoad}};
  assign xfer     = |(in_valid & in_ready);

`ifdef RR_ARB_EN
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] rrIdx;
  logic          unused_sel;

  assign unused_sel = ^sel;

  // Descending scan so the last hit is the one closest to rr_ptr.
  always_comb begin
    grant = '0;
    rrIdx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      rrIdx = SW'((int'(rr_ptr_q) + k) % N);
      if (in_valid[rrIdx]) begin
        grant        = '0;
        grant[rrIdx] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (loadChan == LAST_CH) ? '0 : loadChan + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  localparam logic [SW:0] NUM_CH = (SW + 1)'(N);

  // Out-of-range selects (non power-of-two N) grant nothing.
  always_comb begin
    grant = '0;
    if ({1'b0, sel} < NUM_CH) begin
      grant[sel] = 1'b1;
    end
  end
`endif

  always_comb begin
    loadData = '0;
    loadChan = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        loadData = in_data[i*W +: W];
        loadChan = SW'(i);
      end
    end
  end

  // A load overrides a drain, so back-to-back words flow without a bubble.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = loadData;
      chan_d  = loadChan;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// tb_mux_nto1_pipe: directed stimulus with a queue scoreboard checked by a negedge monitor.
// The fixed-select scenarios run by default; the round-robin sequence runs when RR_ARB_EN is defined.
module tb_mux_nto1_pipe;

  localparam int W  = 5;
  localparam int N  = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] chan;
    logic [W-1:0]  data;
  } word_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [1:0]     sel3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_chan3;
  logic           out_valid3;
  logic           out_ready3;

  int    total = 0;
  int    bad   = 0;
  word_t expQ[$];
  logic  expValid = 1'b0;
  logic  canLoadM;
  logic  accept;
  logic [N-1:0] expReady;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nto1_pipe #(.W(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  task automatic compareHead(input logic pop);
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL out_word: got chan %0d data %0h, expected no word", out_chan, out_data);
    end else begin
      checkOutput("out_data", out_data, expQ[0].data);
      checkOutput("out_chan", out_chan, expQ[0].chan);
      if (pop) void'(expQ.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [SW-1:0] s,
                               input logic [N*W-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic expectWord(input logic [SW-1:0] c, input logic [W-1:0] d);
    expQ.push_back('{chan: c, data: d});
  endtask

  function automatic logic [N*W-1:0] packWords(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                               input logic [W-1:0] w2, input logic [W-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

`ifndef RR_ARB_EN
  // Reference slot model: predicts occupancy and in_ready, checks the held word every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid", out_valid, expValid);
      canLoadM = !expValid || out_ready;
      expReady = '0;
      if (canLoadM) expReady[sel] = 1'b1;
      checkOutput("in_ready", in_ready, expReady);
      if (expValid) compareHead(out_ready);
      accept   = canLoadM && in_valid[sel];
      expValid = accept || (expValid && !out_ready);
    end
  end
`else
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) compareHead(1'b1);
  end
`endif

  initial begin
    rst_n      = 1'b0;
    in_valid   = '0;
    sel        = '0;
    in_data    = '0;
    out_ready  = 1'b0;
    in_valid3  = '0;
    sel3       = '0;
    in_data3   = '0;
    out_ready3 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset out_chan", out_chan, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

`ifndef RR_ARB_EN
    applyStimulus(4'b0100, 2'd2, packWords(5'h00, 5'h00, 5'h13, 5'h00), 1'b1);
    expectWord(2'd2, 5'h13);
    applyStimulus(4'b0000, 2'd0, '0, 1'b1);

    // Stall with the slot full while inputs and select keep changing.
    applyStimulus(4'b0010, 2'd1, packWords(5'h00, 5'h0A, 5'h00, 5'h00), 1'b1);
    expectWord(2'd1, 5'h0A);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1111, SW'(k), packWords(W'(k + 1), W'(k + 2), W'(k + 3), W'(k + 4)), 1'b0);
    end
    applyStimulus(4'b1000, 2'd3, packWords(5'h00, 5'h00, 5'h00, 5'h1F), 1'b1);
    expectWord(2'd3, 5'h1F);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0001, 2'd0, packWords(W'(i + 2), 5'h00, 5'h00, 5'h00), 1'b1);
      expectWord(2'd0, W'(i + 2));
    end
    repeat (2) applyStimulus(4'b0000, 2'd0, '0, 1'b1);

    // Reset while a word is held discards it.
    applyStimulus(4'b0100, 2'd2, packWords(5'h00, 5'h00, 5'h15, 5'h00), 1'b0);
    expectWord(2'd2, 5'h15);
    applyStimulus(4'b0000, 2'd0, '0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset out_data", out_data, 0);
    checkOutput("async reset out_chan", out_chan, 0);
    expQ.delete();
    expValid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) applyStimulus(4'b0000, 2'd0, '0, 1'b1);
    applyStimulus(4'b0001, 2'd0, packWords(5'h07, 5'h00, 5'h00, 5'h00), 1'b1);
    expectWord(2'd0, 5'h07);
    repeat (2) applyStimulus(4'b0000, 2'd0, '0, 1'b1);

    // Three-channel instance: select 3 grants nothing and the held word only drains.
    @(posedge clk);
    #1;
    in_valid3  = 3'b001;
    sel3       = 2'd0;
    in_data3   = {5'h00, 5'h00, 5'h0C};
    out_ready3 = 1'b0;
    @(posedge clk);
    #1;
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    @(negedge clk);
    checkOutput("n3 held out_valid", out_valid3, 1);
    checkOutput("n3 held out_data", out_data3, 5'h0C);
    checkOutput("n3 stalled in_ready", in_ready3, 3'b000);
    @(posedge clk);
    #1;
    out_ready3 = 1'b1;
    @(negedge clk);
    checkOutput("n3 bad sel in_ready", in_ready3, 3'b000);
    checkOutput("n3 pre-drain out_valid", out_valid3, 1);
    @(negedge clk);
    checkOutput("n3 drained out_valid", out_valid3, 0);
    checkOutput("n3 drained out_data", out_data3, 5'h0C);
    checkOutput("n3 drained out_chan", out_chan3, 0);
`else
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 2'd0, packWords(5'd5, 5'd6, 5'd7, 5'd8), 1'b1);
      expectWord(SW'(k % 4), W'(5 + k % 4));
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1010, 2'd0, packWords(5'd5, 5'd6, 5'd7, 5'd8), 1'b1);
      if (k % 2 == 0) expectWord(2'd1, 5'd6);
      else            expectWord(2'd3, 5'd8);
    end
    applyStimulus(4'b0000, 2'd0, '0, 1'b1);
`endif

    for (int c = 0; c < 20 && expQ.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
